cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Shares the single common data bus among result producers (ALU, branch unit, memory read
//  path, ...). Each producer holds a valid result plus CDB_packet_t until consumed; the arbiter
//  grants one per cycle, round-robin, and pulses that producer's yummy. Winner is registered
//  onto the CDB one cycle later, where the ROB and reservation stations snoop it.
// PARAMETERS
//  NUM_REQ   4   number of producers (>=2); index 0..NUM_REQ-1
//  CNT_W     16  width of the saturating grant-conflict performance counter
// PORTS
//  clk           in   1             clock, all state updates on rising edge
//  reset         in   1             synchronous, active-low (0 = reset on next rising edge)
//  req_valid     in   NUM_REQ       producer i holds a result; stays high until its yummy
//  req_pkt       in   NUM_REQ x pkt CDB_packet_t per producer, stable while req_valid[i]
//  hold          in   1             ROB/RS cannot accept a broadcast this cycle
//  flush         in   1             mispredict recovery; discard in-flight broadcast
//  yummy_out     out  NUM_REQ       one-hot/zero; yummy_out[i]=1 -> producer i consumed now
//  cdb_valid     out  1             CDB carries a valid result this cycle
//  cdb_out       out  pkt           CDB_packet_t broadcast
//  conflict_cnt  out  CNT_W         cycles with >=2 requesters granted-out (saturating)
// BEHAVIOUR
//  - Reset (reset==0 at edge): cdb_valid=0, cdb_out='0, rr_ptr=0, conflict_cnt=0.
//    yummy_out is combinational; forced 0 while reset==0.
//  - Grant (combinational): when hold==0 and flush==0, pick the first i with req_valid[i],
//    searching from rr_ptr upward and wrapping NUM_REQ-1 -> 0. Assert yummy_out[i] that cycle.
//  - At the edge of a grant cycle: cdb_out<=req_pkt[i], cdb_valid<=1, rr_ptr<=(i+1) mod NUM_REQ.
//    Latency: request seen in cycle N -> on CDB in cycle N+1. Throughput: 1 result/cycle.
//  - No requester (hold==0): cdb_valid<=0, rr_ptr unchanged, cdb_out unchanged.
//  - hold==1: yummy_out=0; cdb_valid and cdb_out are cleared/kept as follows: cdb_valid<=0
//    (a broadcast already on the bus in the hold cycle counts as consumed), rr_ptr unchanged.
//    Producers keep valid, so no result is lost.
//  - flush==1 (priority over hold and grant): yummy_out=0, cdb_valid<=0, rr_ptr unchanged.
//    The producer that sees flush is responsible for dropping its own held result.
//  - Simultaneous req, hold and flush: flush wins, then hold, then grant.
//  - A producer that deasserts req_valid without a yummy (only legal on flush) must not be
//    granted; the grant is always computed from the current cycle's req_valid.
//  - Fairness: with all NUM_REQ requesting continuously, each is granted once per NUM_REQ
//    cycles; maximum wait for any requester is NUM_REQ-1 grant cycles.
//  - conflict_cnt: +1 on every grant cycle where popcount(req_valid)>=2; saturates at
//    all-ones and holds there. It is not cleared by flush.
//  - At most one yummy_out bit is high in any cycle (assertion).
//  - A reset mid-broadcast drops cdb_valid at the next edge. Producers must also be reset,
//    so no yummy is owed.
// STRUCTURE
//  - Shared package/structs.sv: CDB_packet_t (existing), NUM_CDB_REQ, and producer index
//    localparams (CDB_REQ_ALU=0, CDB_REQ_BR=1, CDB_REQ_MEM=2, CDB_REQ_MUL=3).
//  - Sub-module rr_arbiter #(N): purely combinational; inputs req[N] and ptr; outputs one-hot
//    grant[N], grant_idx, and any. cdb_arbiter adds the rr_ptr, the output register, the
//    hold/flush gating and the counter.
// TESTING
//  1 Reset: hold reset=0 for 2 cycles with req_valid=4'b1111 -> yummy_out=0, cdb_valid=0,
//    conflict_cnt=0.
//  2 Single requester: req_valid=4'b0100, pkt.dest_ROB_entry=5, result=32'hDEAD_BEEF
//    -> yummy_out=4'b0100 same cycle; next cycle cdb_valid=1, entry 5, result DEADBEEF.
//  3 Round-robin: req_valid=4'b1111 held, producers re-present after yummy -> grant order
//    0,1,2,3,0; conflict_cnt=5 after 5 cycles.
//  4 hold: requester 1 valid, hold=1 for 3 cycles -> no yummy, cdb_valid=0; hold drops ->
//    yummy_out=4'b0010, broadcast next cycle, no duplicate.
//  5 flush with req_valid=4'b0011 and hold=1 -> yummy_out=0, cdb_valid=0 next edge, rr_ptr
//    unchanged (next grant goes to the same index as before the flush).
//  6 Saturation: CNT_W=2, 5 conflict cycles -> conflict_cnt stays 2'b11.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Common data bus types and producer indices shared by the CDB arbiter and its producers.
package cdb_arbiter_pkg;

    localparam int NUM_CDB_REQ = 4;
    localparam int ROB_IDX_W   = 5;
    localparam int DATA_W      = 32;

    localparam int CDB_REQ_ALU = 0;
    localparam int CDB_REQ_BR  = 1;
    localparam int CDB_REQ_MEM = 2;
    localparam int CDB_REQ_MUL = 3;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] dest_ROB_entry;
        logic [DATA_W-1:0]    result;
    } CDB_packet_t;

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping to 0.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx,
    output logic          any
);

    // Scan offsets from farthest to nearest so the nearest requester overwrites the rest
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = PW'(idx);
                any        = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: grants one producer per cycle and
// registers the winner's packet onto the CDB one cycle later.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  CDB_packet_t [NUM_REQ-1:0]  req_pkt,
    input  logic                       hold,
    input  logic                       flush,
    output logic [NUM_REQ-1:0]         yummy_out,
    output logic                       cdb_valid,
    output CDB_packet_t                cdb_out,
    output logic [CNT_W-1:0]           conflict_cnt
);

    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]      rr_ptr;
    logic [NUM_REQ-1:0] arb_grant;
    logic [PW-1:0]      arb_idx;
    logic               arb_any;
    logic               grant_en;
    logic               multi_req;
    logic [PW-1:0]      next_ptr;

    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    // Flush outranks hold, hold outranks grant; reset silences yummy immediately
    assign grant_en  = reset & ~flush & ~hold & arb_any;
    assign yummy_out = grant_en ? arb_grant : {NUM_REQ{1'b0}};

    // Clearing the lowest set bit leaves something only when two or more requesters are up
    assign multi_req = |(req_valid & (req_valid - NUM_REQ'(1'b1)));
    assign next_ptr  = (arb_idx == PW'(NUM_REQ - 1)) ? {PW{1'b0}} : arb_idx + PW'(1'b1);

    // Broadcast register, round-robin pointer and saturating conflict counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            cdb_valid    <= 1'b0;
            cdb_out      <= '0;
            rr_ptr       <= '0;
            conflict_cnt <= '0;
        end else if (grant_en) begin
            cdb_valid <= 1'b1;
            cdb_out   <= req_pkt[arb_idx];
            rr_ptr    <= next_ptr;
            if (multi_req && (conflict_cnt != {CNT_W{1'b1}})) begin
                conflict_cnt <= conflict_cnt + CNT_W'(1'b1);
            end else begin
                conflict_cnt <= conflict_cnt;
            end
        end else begin
            cdb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed scoreboard bench for cdb_arbiter; a second instance with a 2-bit counter
// shares the stimulus to exercise counter saturation.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic [3:0]        req_valid;
    CDB_packet_t [3:0] req_pkt;
    logic              hold;
    logic              flush;
    logic [3:0]        yummy_out;
    logic              cdb_valid;
    CDB_packet_t       cdb_out;
    logic [15:0]       conflict_cnt;
    logic [3:0]        yummy2;
    logic              cdb_valid2;
    CDB_packet_t       cdb_out2;
    logic [1:0]        conflict_cnt2;

    CDB_packet_t exp_pkt [4];
    CDB_packet_t sb_q [$];
    int checks = 0;
    int failures = 0;
    int bcasts = 0;
    int exp_bcasts = 0;
    bit mon_on = 1'b1;

    always #5 clk = ~clk;

    cdb_arbiter #(.NUM_REQ(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_pkt(req_pkt),
        .hold(hold), .flush(flush), .yummy_out(yummy_out), .cdb_valid(cdb_valid),
        .cdb_out(cdb_out), .conflict_cnt(conflict_cnt)
    );

    cdb_arbiter #(.NUM_REQ(4), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_pkt(req_pkt),
        .hold(hold), .flush(flush), .yummy_out(yummy2), .cdb_valid(cdb_valid2),
        .cdb_out(cdb_out2), .conflict_cnt(conflict_cnt2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every broadcast must match the oldest expected packet; yummy is one-hot or zero
    always @(negedge clk) begin
        if (mon_on) begin
            checks++;
            if (!$onehot0(yummy_out)) begin
                failures++;
                $display("FAIL yummy_onehot: got %b expected at most one bit", yummy_out);
            end
            if (cdb_valid === 1'b1) begin
                bcasts++;
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_bcast: got entry %0d result %h expected no broadcast",
                             cdb_out.dest_ROB_entry, cdb_out.result);
                end else begin
                    CDB_packet_t e;
                    e = sb_q.pop_front();
                    if (cdb_out !== e) begin
                        failures++;
                        $display("FAIL cdb_out: got entry %0d result %h expected entry %0d result %h",
                                 cdb_out.dest_ROB_entry, cdb_out.result, e.dest_ROB_entry, e.result);
                    end
                end
            end
        end
    end

    // One cycle of stimulus: drive, check yummy at the falling edge, queue the expected broadcast
    task automatic cyc(input logic [3:0] rv, input logic h, input logic f, input logic rst,
                       input logic [3:0] exp_y);
        req_valid = rv;
        hold      = h;
        flush     = f;
        reset     = rst;
        @(negedge clk);
        check("yummy_out", {28'd0, yummy_out}, {28'd0, exp_y});
        check("yummy_sat", {28'd0, yummy2}, {28'd0, exp_y});
        for (int i = 0; i < 4; i++) begin
            if (exp_y[i]) begin
                sb_q.push_back(exp_pkt[i]);
                exp_bcasts++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_pkt[0] = '{dest_ROB_entry: 5'd1, result: 32'h1111_0000};
        exp_pkt[1] = '{dest_ROB_entry: 5'd3, result: 32'hCAFE_0001};
        exp_pkt[2] = '{dest_ROB_entry: 5'd5, result: 32'hDEAD_BEEF};
        exp_pkt[3] = '{dest_ROB_entry: 5'd7, result: 32'h7777_0003};
        for (int i = 0; i < 4; i++) req_pkt[i] = exp_pkt[i];
        reset = 1'b0; req_valid = 4'b1111; hold = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;

        // 1: reset with all requesting
        cyc(4'b1111, 1'b0, 1'b0, 1'b0, 4'b0000);
        cyc(4'b1111, 1'b0, 1'b0, 1'b0, 4'b0000);
        check("rst_cdb_valid", {31'd0, cdb_valid}, 32'd0);
        check("rst_cdb_out", {cdb_out.dest_ROB_entry, cdb_out.result[26:0]}, 32'd0);
        check("rst_conflict", {16'd0, conflict_cnt}, 32'd0);

        // 2: single requester 2
        cyc(4'b0100, 1'b0, 1'b0, 1'b1, 4'b0100);
        check("single_valid", {31'd0, cdb_valid}, 32'd1);
        cyc(4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000);

        // 3: round robin from pointer 0 with everyone requesting
        cyc(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
        cyc(4'b1111, 1'b0, 1'b0, 1'b1, 4'b0001);
        cyc(4'b1111, 1'b0, 1'b0, 1'b1, 4'b0010);
        cyc(4'b1111, 1'b0, 1'b0, 1'b1, 4'b0100);
        cyc(4'b1111, 1'b0, 1'b0, 1'b1, 4'b1000);
        cyc(4'b1111, 1'b0, 1'b0, 1'b1, 4'b0001);
        check("rr_conflict", {16'd0, conflict_cnt}, 32'd5);
        check("sat_conflict", {30'd0, conflict_cnt2}, 32'd3);
        cyc(4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000);

        // 4: hold for three cycles, then a single broadcast
        cyc(4'b0010, 1'b1, 1'b0, 1'b1, 4'b0000);
        cyc(4'b0010, 1'b1, 1'b0, 1'b1, 4'b0000);
        cyc(4'b0010, 1'b1, 1'b0, 1'b1, 4'b0000);
        check("hold_valid", {31'd0, cdb_valid}, 32'd0);
        cyc(4'b0010, 1'b0, 1'b0, 1'b1, 4'b0010);
        cyc(4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000);
        check("hold_cnt", {16'd0, conflict_cnt}, 32'd5);

        // 5: flush over hold, then flush alone; pointer stays at 2
        cyc(4'b0011, 1'b1, 1'b1, 1'b1, 4'b0000);
        check("flush_valid", {31'd0, cdb_valid}, 32'd0);
        cyc(4'b0011, 1'b0, 1'b1, 1'b1, 4'b0000);
        cyc(4'b0011, 1'b0, 1'b0, 1'b1, 4'b0001);
        cyc(4'b0010, 1'b0, 1'b0, 1'b1, 4'b0010);
        cyc(4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000);
        check("flush_cnt", {16'd0, conflict_cnt}, 32'd6);
        check("sat_hold", {30'd0, conflict_cnt2}, 32'd3);

        // Reset in the middle of a broadcast
        cyc(4'b1000, 1'b0, 1'b0, 1'b1, 4'b1000);
        cyc(4'b1000, 1'b0, 1'b0, 1'b0, 4'b0000);
        check("midrst_valid", {31'd0, cdb_valid}, 32'd0);
        check("midrst_cnt", {16'd0, conflict_cnt}, 32'd0);
        cyc(4'b1010, 1'b0, 1'b0, 1'b1, 4'b0010);
        cyc(4'b1000, 1'b0, 1'b0, 1'b1, 4'b1000);
        cyc(4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000);
        check("post_rst_cnt", {16'd0, conflict_cnt}, 32'd1);
        cyc(4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000);

        mon_on = 1'b0;
        check("sb_empty", sb_q.size(), 32'd0);
        check("bcast_count", bcasts, exp_bcasts);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
